// File: rtl/eth_tx_frame_sequencer.sv
// Transmit frame sequencer: builds DA/SA/optional 802.1Q tag/EtherType from a
// header descriptor, streams a FWFT payload FIFO onto an 8-bit AXI-Stream, and
// handles short-frame padding, long-frame truncation, underrun abort and IFG.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a header descriptor while payload is available
// HEADER  | sending DA, SA, optional VLAN tag and EtherType bytes
// PAYLOAD | forwarding FIFO bytes; watches for last/truncation/underrun
// PAD     | filling a short frame up to MIN_PAYLOAD with PAD_BYTE
// ABORT   | single errored tlast beat after a FIFO underrun
// DRAIN   | discarding the rest of the frame from the FIFO up to fifo_last
// GAP     | inter-frame gap, IFG_CYCLES idle cycles
module eth_tx_frame_sequencer #(
  parameter int         MIN_PAYLOAD  = 46,
  parameter int         MAX_PAYLOAD  = 1500,
  parameter logic [7:0] PAD_BYTE     = 8'h00,
  parameter int         IFG_CYCLES   = 12,
  parameter int         UNDERRUN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [47:0] hdr_da,
  input  logic [47:0] hdr_sa,
  input  logic [15:0] hdr_type,
  input  logic        hdr_vlan_en,
  input  logic [15:0] hdr_vlan_tci,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_last,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_PAYLOAD);
  localparam logic [CW-1:0] MIN_M1 = CW'(MIN_PAYLOAD - 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PAYLOAD);
  localparam logic [CW-1:0] UND_C  = CW'(UNDERRUN_CYC);
  localparam logic [CW-1:0] IFG_M1 = CW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, ABORT, DRAIN, GAP} state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t        state;
  logic [47:0]   da_q, sa_q;
  logic [15:0]   type_q, tci_q;
  logic          vlan_q;
  logic [4:0]    hdr_len, byte_idx;
  logic [CW-1:0] pay_cnt, empty_cnt, gap_cnt;
  logic [CW-1:0] pay_inc;
  logic          frame_done_q, frame_err_q;
  logic [7:0]    hdr_byte;
  logic          beat;

  assign pay_inc    = pay_cnt + ONE;
  assign beat       = m_tvalid & m_tready;
  assign busy       = rst_n & (state != IDLE);
  assign frame_done = rst_n & frame_done_q;
  assign frame_err  = rst_n & frame_err_q;

  // Select the header byte for the current position; VLAN shifts the type by 4.
  always_comb begin
    hdr_byte = 8'h00;
    case (byte_idx)
      5'd0:  hdr_byte = da_q[47:40];
      5'd1:  hdr_byte = da_q[39:32];
      5'd2:  hdr_byte = da_q[31:24];
      5'd3:  hdr_byte = da_q[23:16];
      5'd4:  hdr_byte = da_q[15:8];
      5'd5:  hdr_byte = da_q[7:0];
      5'd6:  hdr_byte = sa_q[47:40];
      5'd7:  hdr_byte = sa_q[39:32];
      5'd8:  hdr_byte = sa_q[31:24];
      5'd9:  hdr_byte = sa_q[23:16];
      5'd10: hdr_byte = sa_q[15:8];
      5'd11: hdr_byte = sa_q[7:0];
      5'd12: hdr_byte = vlan_q ? 8'h81 : type_q[15:8];
      5'd13: hdr_byte = vlan_q ? 8'h00 : type_q[7:0];
      5'd14: hdr_byte = tci_q[15:8];
      5'd15: hdr_byte = tci_q[7:0];
      5'd16: hdr_byte = type_q[15:8];
      5'd17: hdr_byte = type_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Stream-side outputs decoded from state; everything is forced low in reset.
  always_comb begin
    hdr_ready  = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = 8'h00;
    m_tlast    = 1'b0;
    m_tuser    = 1'b0;
    fifo_rd_en = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: hdr_ready = !fifo_empty;
        HEADER: begin
          m_tvalid = 1'b1;
          m_tdata  = hdr_byte;
        end
        PAYLOAD: begin
          m_tvalid   = !fifo_empty;
          m_tdata    = fifo_data;
          fifo_rd_en = m_tvalid & m_tready;
          // A last byte landing exactly on MAX_PAYLOAD is a good frame.
          if (fifo_last) begin
            m_tlast = m_tvalid && (pay_inc >= MIN_C);
          end else begin
            m_tlast = m_tvalid && (pay_inc == MAX_C);
            m_tuser = m_tvalid && (pay_inc == MAX_C);
          end
        end
        PAD: begin
          m_tvalid = 1'b1;
          m_tdata  = PAD_BYTE;
          m_tlast  = (pay_cnt == MIN_M1);
        end
        ABORT: begin
          m_tvalid = 1'b1;
          m_tdata  = PAD_BYTE;
          m_tlast  = 1'b1;
          m_tuser  = 1'b1;
        end
        DRAIN: fifo_rd_en = !fifo_empty;
        default: ;
      endcase
    end
  end

  // Frame sequencing state machine with header capture and byte counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      da_q         <= '0;
      sa_q         <= '0;
      type_q       <= '0;
      tci_q        <= '0;
      vlan_q       <= 1'b0;
      hdr_len      <= '0;
      byte_idx     <= '0;
      pay_cnt      <= '0;
      empty_cnt    <= '0;
      gap_cnt      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (beat && m_tlast) begin
        frame_done_q <= !m_tuser;
        frame_err_q  <= m_tuser;
      end
      if (state != GAP) gap_cnt <= '0;
      case (state)
        IDLE: begin
          if (hdr_valid && hdr_ready) begin
            da_q      <= hdr_da;
            sa_q      <= hdr_sa;
            type_q    <= hdr_type;
            tci_q     <= hdr_vlan_tci;
            vlan_q    <= hdr_vlan_en;
            hdr_len   <= hdr_vlan_en ? 5'd18 : 5'd14;
            byte_idx  <= '0;
            pay_cnt   <= '0;
            empty_cnt <= '0;
            state     <= HEADER;
          end
        end
        HEADER: begin
          if (beat) begin
            byte_idx <= byte_idx + 5'd1;
            if (byte_idx == hdr_len - 5'd1) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (beat) begin
            empty_cnt <= '0;
            pay_cnt   <= pay_inc;
            if (fifo_last) state <= (pay_inc >= MIN_C) ? AFTER_FRAME : PAD;
            else if (pay_inc == MAX_C) state <= DRAIN;
          end else if (fifo_empty) begin
            empty_cnt <= empty_cnt + ONE;
            if (empty_cnt + ONE == UND_C) state <= ABORT;
          end
        end
        PAD: begin
          if (beat) begin
            pay_cnt <= pay_inc;
            if (pay_cnt == MIN_M1) state <= AFTER_FRAME;
          end
        end
        ABORT: if (beat) state <= DRAIN;
        DRAIN: if (fifo_rd_en && fifo_last) state <= AFTER_FRAME;
        GAP: begin
          if (gap_cnt == IFG_M1) state <= IDLE;
          else gap_cnt <= gap_cnt + ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
// Scoreboard bench for eth_tx_frame_sequencer: directed frames push expected
// beats and done/err events into queues; a negedge monitor pops and compares.
module tb_eth_tx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [47:0] hdr_da = '0, hdr_sa = '0;
  logic [15:0] hdr_type = '0, hdr_vlan_tci = '0;
  logic        hdr_vlan_en = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_last = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast, m_tuser;
  logic        frame_done, frame_err, busy;

  eth_tx_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_da(hdr_da), .hdr_sa(hdr_sa), .hdr_type(hdr_type),
    .hdr_vlan_en(hdr_vlan_en), .hdr_vlan_tci(hdr_vlan_tci),
    .fifo_data(fifo_data), .fifo_last(fifo_last), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [9:0] expq[$];   // {data, last, user}
  logic [1:0] evq[$];    // {done, err}
  logic [8:0] fq[$];     // {last, data}
  int  cyc = 0, pop_cnt = 0, starve_at = 0, starve_left = 0, rd_cnt = 0;
  int  last_tlast_cyc = 0;
  bit  pop_q = 1'b0, toggle_ready = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [9:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model and ready pattern: updated 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_q) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pop_cnt++;
      if (pop_cnt == starve_at) starve_left = 4;
    end
    pop_q = 1'b0;
    m_tready = toggle_ready ? ~m_tready : 1'b1;
    fifo_empty = (fq.size() == 0) || (starve_left > 0);
    if (starve_left > 0) starve_left--;
    if (fq.size() > 0) {fifo_last, fifo_data} = fq[0];
    else begin
      fifo_last = 1'b0;
      fifo_data = 8'h00;
    end
  end

  // Monitor: sample at the falling edge, compare beats and frame events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) begin
        pop_q = 1'b1;
        rd_cnt++;
      end
      if (stall_prev) check("stall_hold", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, data_prev});
      stall_prev = m_tvalid && !m_tready;
      data_prev  = m_tdata;
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat: unexpected beat data=%02h last=%0b user=%0b", m_tdata, m_tlast, m_tuser);
        end else begin
          e = expq.pop_front();
          check("beat", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, e});
        end
        if (m_tlast) last_tlast_cyc = cyc;
      end
      if (frame_done || frame_err) begin
        if (evq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL frame_evt: unexpected done=%0b err=%0b required none", frame_done, frame_err);
        end else check("frame_evt", {30'd0, frame_done, frame_err}, {30'd0, evq.pop_front()});
      end
    end else stall_prev = 1'b0;
  end

  task automatic exp_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty,
                         input logic vl, input logic [15:0] tci);
    for (int i = 0; i < 6; i++) expq.push_back({da[47-8*i -: 8], 2'b00});
    for (int i = 0; i < 6; i++) expq.push_back({sa[47-8*i -: 8], 2'b00});
    if (vl) begin
      expq.push_back({8'h81, 2'b00});
      expq.push_back({8'h00, 2'b00});
      expq.push_back({tci[15:8], 2'b00});
      expq.push_back({tci[7:0], 2'b00});
    end
    expq.push_back({ty[15:8], 2'b00});
    expq.push_back({ty[7:0], 2'b00});
  endtask

  task automatic exp_data(input int n, input logic [7:0] seed, input logic lst, input logic usr);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = seed + 8'(i);
      expq.push_back({d, (i == n-1) ? lst : 1'b0, (i == n-1) ? usr : 1'b0});
    end
  endtask

  task automatic exp_pad(input int n);
    for (int i = 0; i < n; i++) expq.push_back({8'h00, (i == n-1), 1'b0});
  endtask

  task automatic load_fifo(input int n, input logic [7:0] seed);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = seed + 8'(i);
      fq.push_back({(i == n-1), d});
    end
    pop_cnt = 0;
  endtask

  task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty,
                          input logic vl, input logic [15:0] tci);
    bit got = 1'b0;
    @(posedge clk); #2;
    hdr_da = da; hdr_sa = sa; hdr_type = ty; hdr_vlan_en = vl; hdr_vlan_tci = tci;
    hdr_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (hdr_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    hdr_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL hdr_accept: hdr_ready never rose within 300 cycles");
    end
  endtask

  task automatic wait_end(input int limit);
    int k = 0;
    while (k < limit && (expq.size() != 0 || evq.size() != 0 || fq.size() != 0)) begin
      @(negedge clk); #1;
      k++;
    end
    if (expq.size() != 0 || evq.size() != 0 || fq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: pending beats=%0d events=%0d fifo=%0d required 0",
               expq.size(), evq.size(), fq.size());
      expq.delete(); evq.delete(); fq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] DA1 = 48'h010203040506;
  localparam logic [47:0] SA1 = 48'h0A0B0C0D0E0F;

  initial begin
    // Reset with payload present: every output must stay low.
    fq.push_back(9'h1AA);
    repeat (3) @(negedge clk);
    check("reset_outs", {24'd0, hdr_ready, m_tvalid, m_tlast, m_tuser, fifo_rd_en, busy, frame_done, frame_err}, 32'd0);
    fq.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);

    // 1: plain frame, 60-byte payload, then measure the inter-frame gap.
    exp_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    exp_data(60, 8'h10, 1'b1, 1'b0);
    evq.push_back(2'b10);
    load_fifo(60, 8'h10);
    send_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    wait_end(3000);
    fq.push_back(9'h1AA);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (hdr_ready) break;
    end
    check("ifg_gap", cyc - last_tlast_cyc, 13);
    fq.delete();

    // 2: VLAN frame, 10-byte payload padded to 46.
    exp_hdr(DA1, SA1, 16'h88B5, 1'b1, 16'h0123);
    exp_data(10, 8'h40, 1'b0, 1'b0);
    exp_pad(36);
    evq.push_back(2'b10);
    load_fifo(10, 8'h40);
    send_hdr(DA1, SA1, 16'h88B5, 1'b1, 16'h0123);
    wait_end(3000);

    // 3: 50-byte payload with ready toggling every cycle.
    toggle_ready = 1'b1;
    exp_hdr(48'hFFFFFFFFFFFF, SA1, 16'h0806, 1'b0, 16'h0);
    exp_data(50, 8'h80, 1'b1, 1'b0);
    evq.push_back(2'b10);
    load_fifo(50, 8'h80);
    rd_cnt = 0;
    send_hdr(48'hFFFFFFFFFFFF, SA1, 16'h0806, 1'b0, 16'h0);
    wait_end(3000);
    check("rd_en_count", rd_cnt, 50);
    toggle_ready = 1'b0;

    // 4: FIFO starves after byte 20 for 4 cycles -> abort, drain the rest.
    starve_at = 20;
    exp_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    exp_data(20, 8'hC0, 1'b0, 1'b0);
    expq.push_back({8'h00, 1'b1, 1'b1});
    evq.push_back(2'b01);
    load_fifo(40, 8'hC0);
    send_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    wait_end(3000);
    starve_at = 0;

    // 5: 1600-byte payload truncated at 1500, remaining 100 drained.
    exp_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    exp_data(1500, 8'h05, 1'b1, 1'b1);
    evq.push_back(2'b01);
    load_fifo(1600, 8'h05);
    send_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    wait_end(5000);

    // 5b: last byte exactly at 1500 is a good frame.
    exp_hdr(SA1, DA1, 16'h86DD, 1'b0, 16'h0);
    exp_data(1500, 8'h77, 1'b1, 1'b0);
    evq.push_back(2'b10);
    load_fifo(1500, 8'h77);
    send_hdr(SA1, DA1, 16'h86DD, 1'b0, 16'h0);
    wait_end(5000);

    // 6: reset pulse during payload byte 30, then a fresh 46-byte frame.
    exp_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    exp_data(60, 8'h20, 1'b1, 1'b0);
    load_fifo(60, 8'h20);
    send_hdr(DA1, SA1, 16'h0800, 1'b0, 16'h0);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (pop_cnt >= 29) break;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    expq.delete(); evq.delete(); fq.delete();
    @(negedge clk);
    check("midreset_outs", {24'd0, hdr_ready, m_tvalid, m_tlast, m_tuser, fifo_rd_en, busy, frame_done, frame_err}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("midreset_idle", {30'd0, busy, m_tvalid}, 32'd0);

    exp_hdr(48'h00112233AABB, SA1, 16'h0800, 1'b0, 16'h0);
    exp_data(46, 8'h33, 1'b1, 1'b0);
    evq.push_back(2'b10);
    load_fifo(46, 8'h33);
    send_hdr(48'h00112233AABB, SA1, 16'h0800, 1'b0, 16'h0);
    wait_end(3000);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_sequencer.md
Name: eth_tx_frame_sequencer

Overview:
Parametrised transmit frame sequencer for the tri-mode Ethernet MAC client path. It sits between the header/payload source (a header descriptor handshake plus a first-word-fall-through payload FIFO) and the MAC's 8-bit AXI-Stream TX input. For each frame it builds DA, SA, an optional 802.1Q tag and the EtherType, then streams the payload. Beyond the previous controller, it adds minimum-length padding, maximum-length truncation, FIFO underrun abort, a programmable inter-frame gap, and error/done reporting.

Parameters:
MIN_PAYLOAD, 46, minimum payload bytes; shorter frames are padded with PAD_BYTE.
MAX_PAYLOAD, 1500, maximum payload bytes; longer frames are truncated and flagged.
PAD_BYTE, 8'h00, value of each pad byte.
IFG_CYCLES, 12, idle cycles after the tlast handshake before the next frame may start (0 is legal).
UNDERRUN_CYC, 4, consecutive FIFO-empty cycles in PAYLOAD before the frame is aborted.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
hdr_valid  in  1  header descriptor valid
hdr_ready  out  1  header accepted; asserted only in IDLE with !fifo_empty and rst_n high
hdr_da  in  48  destination MAC; byte [47:40] is sent first
hdr_sa  in  48  source MAC; byte [47:40] is sent first
hdr_type  in  16  EtherType/length; MSB byte first
hdr_vlan_en  in  1  insert 802.1Q tag
hdr_vlan_tci  in  16  VLAN TCI
fifo_data  in  8  payload byte (FWFT)
fifo_last  in  1  marks the last payload byte
fifo_empty  in  1  payload FIFO empty
fifo_rd_en  out  1  pop the payload FIFO
m_tdata  out  8  AXIS data
m_tvalid  out  1  AXIS valid
m_tready  in  1  AXIS ready
m_tlast  out  1  AXIS last
m_tuser  out  1  frame error, qualified with m_tlast
frame_done  out  1  one-cycle pulse on a good tlast handshake
frame_err  out  1  one-cycle pulse on an errored tlast handshake
busy  out  1  high whenever the state is not IDLE

Behaviour:
- States: IDLE, HEADER, PAYLOAD, PAD, ABORT, DRAIN, GAP.
- Reset: state IDLE, counters 0, header registers 0. All outputs are 0, including hdr_ready, for the whole time rst_n is low.
- Reset mid-frame: the frame is dropped with no tlast, and the FIFO is not drained.
- A beat transfers when m_tvalid & m_tready.
- IDLE:
  - hdr_ready = !fifo_empty.
  - On handshake, capture hdr_* and set hdr_len = 18 if vlan_en, else 14; clear byte_idx and pay_cnt; go to HEADER.
  - First header byte is valid the next cycle.
- HEADER:
  - m_tvalid = 1; m_tdata is the byte at byte_idx.
  - Byte order: DA[0..5], SA[0..5], then 8'h81, 8'h00, TCI_hi, TCI_lo if VLAN, then type_hi, type_lo.
  - byte_idx increments per beat; the last header beat goes to PAYLOAD. m_tlast = 0.
- PAYLOAD:
  - m_tvalid = !fifo_empty; m_tdata = fifo_data; fifo_rd_en = m_tvalid & m_tready; pay_cnt increments per beat.
  - fifo_last beat with pay_cnt+1 >= MIN_PAYLOAD: m_tlast = 1, m_tuser = 0, go to GAP.
  - fifo_last beat with pay_cnt+1 < MIN_PAYLOAD: m_tlast = 0, go to PAD.
  - Beat where pay_cnt+1 == MAX_PAYLOAD and fifo_last = 0: m_tlast = 1, m_tuser = 1, go to DRAIN.
  - Empty-cycle counter: increments on each fifo_empty cycle and clears on any beat. When it reaches UNDERRUN_CYC, go to ABORT.
- PAD:
  - m_tvalid = 1; m_tdata = PAD_BYTE; pay_cnt increments per beat.
  - m_tlast = 1 when pay_cnt == MIN_PAYLOAD-1; that beat goes to GAP.
- ABORT:
  - Emits one beat: m_tdata = PAD_BYTE, m_tlast = 1, m_tuser = 1.
  - On handshake go to DRAIN.
- DRAIN:
  - m_tvalid = 0; fifo_rd_en = !fifo_empty.
  - Popping a byte with fifo_last = 1 goes to GAP.
- GAP:
  - Counts IFG_CYCLES cycles with m_tvalid = 0, then goes to IDLE. With IFG_CYCLES = 0, go straight to IDLE.
  - DRAIN does not count toward the gap.
- frame_done/frame_err are registered and assert the cycle after the tlast handshake: frame_err if m_tuser was 1, else frame_done.
- Once asserted in HEADER or PAD, m_tvalid and m_tdata hold stable until the handshake.
- Counters are $clog2(MAX_PAYLOAD+1) bits wide and never wrap within a frame.
- Simultaneous events:
  - A fifo_last beat with pay_cnt+1 == MAX_PAYLOAD is a good frame (tuser = 0), not truncated.
  - MIN_PAYLOAD takes precedence only when pay_cnt+1 < MIN_PAYLOAD.

Test Plan:
- No VLAN, DA=01:02:03:04:05:06, 60-byte payload, m_tready=1 -> 74 beats, tlast on beat 74, tuser=0, frame_done pulse, hdr_ready low for the following 12 cycles.
- VLAN TCI=16'h0123, 10-byte payload -> 18 header bytes including 81 00 01 23, 10 data bytes, 36 beats of 8'h00, tlast on beat 64.
- 50-byte payload with m_tready toggling 1/0 every cycle -> m_tdata stable while stalled, exactly 50 fifo_rd_en pulses, 64 beats total.
- FIFO starves after payload byte 20 for 4 cycles -> abort beat with tlast=1, tuser=1, frame_err pulse; remaining bytes drained through fifo_last, then GAP.
- 1600-byte payload -> tlast+tuser on payload byte 1500, remaining 100 bytes drained, frame_err pulse.
- rst_n low for 1 cycle during payload byte 30 -> all outputs 0 next cycle, state IDLE; a subsequent new header is accepted normally.
